// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding architectural HI/LO.
// One radix-2 step per cycle; results land on HI/LO on the final step edge.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoAccess,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             StallReq,
  output logic             state_dbg
);

  // Handshake: an instruction in execute proceeds on a clock edge only when
  // StallReq is 0; while StallReq is 1 the pipeline holds and re-presents it.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE  = 1;
  localparam logic [2*WIDTH-1:0] ONE2 = 1;

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opd;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_n, mq_n;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign Busy      = (state == RUN);
  assign StallReq  = Busy & (Start | HiLoAccess);
  assign state_dbg = state;

  // Operand magnitudes; Op[0] selects the signed variants.
  assign sign_a = Op[0] & A[WIDTH-1];
  assign sign_b = Op[0] & B[WIDTH-1];
  assign mag_a  = sign_a ? (~A + ONE) : A;
  assign mag_b  = sign_b ? (~B + ONE) : B;

  always_comb begin
    add     = {1'b0, acc} + (mq[0] ? {1'b0, opd} : '0);
    shifted = {acc, mq[WIDTH-1]};
    diff    = shifted - {1'b0, opd};
    acc_n   = add[WIDTH:1];
    mq_n    = {add[0], mq[WIDTH-1:1]};
    if (is_div) begin
      // Restoring step: keep the difference only when it did not go negative.
      acc_n = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      mq_n  = {mq[WIDTH-2:0], ~diff[WIDTH]};
    end
    prod     = {acc_n, mq_n};
    prod_fix = neg_q ? (~prod + ONE2) : prod;
    quo_fix  = neg_q ? (~mq_n + ONE) : mq_n;
    rem_fix  = neg_r ? (~acc_n + ONE) : acc_n;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      mq     <= '0;
      opd    <= '0;
      HI     <= '0;
      LO     <= '0;
      Done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (!StallReq) begin
            if (WriteHi) HI <= WriteData;
            if (WriteLo) LO <= WriteData;
            if (Start) begin
              state  <= RUN;
              count  <= CW'(WIDTH);
              is_div <= Op[1];
              neg_q  <= sign_a ^ sign_b;
              neg_r  <= Op[1] & sign_a;
              acc    <= '0;
              mq     <= mag_a;
              opd    <= mag_b;
            end
          end
        end
        RUN: begin
          acc   <= acc_n;
          mq    <= mq_n;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= IDLE;
            Done  <= 1'b1;
            if (is_div) begin
              HI <= rem_fix;
              LO <= quo_fix;
            end else begin
              HI <= prod_fix[2*WIDTH-1:WIDTH];
              LO <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit with an arithmetic
// reference model and an expected-result queue.
module tb_muldiv_unit;

  logic        Clock = 1'b0;
  logic        Reset, Start, HiLoAccess, WriteHi, WriteLo;
  logic [1:0]  Op;
  logic [31:0] A, B, WriteData;
  logic [31:0] HI, LO;
  logic        Busy, Done, StallReq, state_dbg;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiLoAccess(HiLoAccess), .WriteHi(WriteHi), .WriteLo(WriteLo),
    .WriteData(WriteData), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done),
    .StallReq(StallReq), .state_dbg(state_dbg)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {HI,LO} from plain arithmetic on the architectural rules.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sp;
    logic [31:0] ma, mb, q, r;
    case (op)
      2'b00: return {32'b0, a} * {32'b0, b};
      2'b01: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
        r  = (mb == 0) ? ma : ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
      end
    endcase
  endfunction

  task automatic wait_idle(output int n);
    n = 0;
    while (Busy && n < 40) begin
      n++;
      @(negedge Clock);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expv);
    logic [31:0] hi0, lo0;
    logic [63:0] e;
    int n;
    bit stable;
    @(negedge Clock);
    Start = 1'b1; Op = op; A = a; B = b;
    exp_q.push_back(expv);
    @(posedge Clock); #1;
    Start = 1'b0; A = $urandom; B = $urandom; Op = 2'($urandom_range(0, 3));
    hi0 = HI; lo0 = LO; stable = 1'b1; n = 0;
    @(negedge Clock);
    while (Busy && n < 40) begin
      n++;
      if (HI !== hi0 || LO !== lo0) stable = 1'b0;
      @(negedge Clock);
    end
    e = exp_q.pop_front();
    check({tag, " busy_cycles"}, 32'(n), 32'd32);
    check({tag, " hilo_stable"}, {31'b0, stable}, 32'd1);
    check({tag, " done"}, {31'b0, Done}, 32'd1);
    check({tag, " hi"}, HI, e[63:32]);
    check({tag, " lo"}, LO, e[31:0]);
    @(negedge Clock);
    check({tag, " done_clear"}, {31'b0, Done}, 32'd0);
  endtask

  initial begin
    int n, bad;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    // Reset held 3 cycles with competing inputs active.
    Reset = 1'b1; Start = 1'b1; Op = 2'b00; A = 32'd9; B = 32'd9;
    HiLoAccess = 1'b0; WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'hFFFF;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0; Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
    #1;
    check("reset hi", HI, 32'd0);
    check("reset lo", LO, 32'd0);
    check("reset busy", {31'b0, Busy}, 32'd0);
    check("reset done", {31'b0, Done}, 32'd0);
    check("reset stall", {31'b0, StallReq}, 32'd0);

    // Directed corner cases.
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 2'b01, -32'sd3, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg", 2'b11, -32'sd7, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", 2'b10, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("div_zero_neg", 2'b11, -32'sd5, 32'd0, model(2'b11, -32'sd5, 32'd0));

    // HI/LO access stalls from busy cycle 5 until the Done cycle.
    @(negedge Clock);
    Start = 1'b1; Op = 2'b10; A = 32'd100; B = 32'd7;
    @(posedge Clock); #1;
    Start = 1'b0;
    n = 0; bad = 0;
    @(negedge Clock);
    while (Busy && n < 40) begin
      n++;
      if (n == 5) begin
        HiLoAccess = 1'b1; WriteLo = 1'b1; WriteData = 32'hDEAD;
      end
      #1;
      if (StallReq !== (n >= 5)) bad++;
      @(negedge Clock);
    end
    WriteLo = 1'b0;
    #1;
    check("stall pattern", 32'(bad), 32'd0);
    check("stall busy_cycles", 32'(n), 32'd32);
    check("stall release", {31'b0, StallReq}, 32'd0);
    check("stall done", {31'b0, Done}, 32'd1);
    check("mflo", LO, 32'd14);
    check("mfhi", HI, 32'd2);
    HiLoAccess = 1'b0;

    // Write and Start on the same edge: write lands, result overwrites later.
    @(negedge Clock);
    Start = 1'b1; Op = 2'b00; A = 32'd2; B = 32'd3; WriteHi = 1'b1; WriteData = 32'hABCD;
    @(posedge Clock); #1;
    Start = 1'b0; WriteHi = 1'b0;
    check("wr_start hi", HI, 32'hABCD);
    check("wr_start busy", {31'b0, Busy}, 32'd1);
    @(negedge Clock);
    wait_idle(n);
    check("wr_start done", {31'b0, Done}, 32'd1);
    check("wr_start hi_final", HI, 32'd0);
    check("wr_start lo_final", LO, 32'd6);

    // Start held high: back-to-back operations.
    @(negedge Clock);
    Start = 1'b1; Op = 2'b00; A = 32'd3; B = 32'd4;
    @(posedge Clock); #1;
    check("b2b stall", {31'b0, StallReq}, 32'd1);
    @(negedge Clock);
    wait_idle(n);
    check("b2b first_cycles", 32'(n), 32'd32);
    check("b2b first_lo", LO, 32'd12);
    check("b2b first_stall", {31'b0, StallReq}, 32'd0);
    A = 32'd5; B = 32'd6;
    @(negedge Clock);
    check("b2b relaunch", {31'b0, Busy}, 32'd1);
    Start = 1'b0;
    wait_idle(n);
    check("b2b second_lo", LO, 32'd30);

    // Reset mid-operation aborts without a Done pulse.
    @(negedge Clock);
    Start = 1'b1; Op = 2'b00; A = 32'd5; B = 32'd5;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (10) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort busy", {31'b0, Busy}, 32'd0);
    check("abort hi", HI, 32'd0);
    check("abort lo", LO, 32'd0);
    bad = 0;
    repeat (35) begin
      @(negedge Clock);
      if (Done !== 1'b0) bad++;
    end
    check("abort no_done", 32'(bad), 32'd0);
    WriteLo = 1'b1; WriteData = 32'h1234;
    @(negedge Clock);
    WriteLo = 1'b0;
    check("mtlo lo", LO, 32'h1234);
    check("mtlo hi", HI, 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage of the 3-stage pipeline, holding architectural HI/LO.
- Executes MULT, MULTU, DIV and DIVU over 32 cycles while independent instructions keep flowing.
- Drives the Stall input of the hazard/forwarding control when an instruction touches HI/LO or issues a new mul/div while the unit is busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- Clock  in  1  rising-edge clock, the single clock of the block.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  execute-stage instruction is MULT/MULTU/DIV/DIVU.
- Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  in  WIDTH  rs operand (multiplicand / dividend).
- B  in  WIDTH  rt operand (multiplier / divisor).
- HiLoAccess  in  1  execute-stage instruction is MFHI, MFLO, MTHI or MTLO.
- WriteHi  in  1  MTHI.
- WriteLo  in  1  MTLO.
- WriteData  in  WIDTH  rs value for MTHI/MTLO.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse after HI/LO are updated by an operation.
- StallReq  out  1  to hazard control Stall input.

Behaviour:
- Reset: state IDLE; HI=0, LO=0, Busy=0, Done=0, counter=0, all working registers 0. Reset wins over every other input in the same cycle.
- Reset asserted mid-operation aborts the operation. HI/LO go to 0 and no Done pulse is produced.
- States:
  - IDLE -> RUN on a clock edge with Start=1 and StallReq=0. A, B and Op are captured on that edge and the counter is loaded with WIDTH.
  - RUN: one radix-2 step per cycle (shift-add multiply, restoring divide) on operand magnitudes. Counter decrements each cycle.
  - RUN -> IDLE on the edge where the counter reaches 0. HI/LO are written with the sign-corrected result on that edge.
- Timing: Busy=1 for exactly WIDTH cycles, from the cycle after the capturing edge. Done=1 in the first IDLE cycle, then 0.
- Capture edge is E. New HI/LO are visible from edge E+WIDTH onward.
- Multiply: {HI,LO} = 2*WIDTH-bit product.
  - MULTU: unsigned.
  - MULT: two's-complement; negated if the operand signs differ.
- Divide: LO = quotient, HI = remainder.
  - DIVU: unsigned.
  - DIV: quotient negative if the signs differ; remainder takes the sign of the dividend.
  - Most-negative / -1 gives LO=0x80000000, HI=0.
- Divide by zero:
  - DIVU: LO=0xFFFFFFFF, HI=A.
  - DIV: same restoring-algorithm result on magnitudes, then sign correction per the DIV rules.
  - No exception.
- MTHI/MTLO write WriteData on the edge when state is IDLE and StallReq=0. WriteHi and WriteLo may both be set.
- A Start and a write in the same cycle: the writes apply, then the operation later overwrites HI/LO.
- StallReq = Busy & (Start | HiLoAccess), combinational. It is 0 in IDLE.
- While StallReq=1, Start and writes are ignored; the stalled instruction is re-presented by the pipeline.
- On the cycle Done=1, Busy=0, so a held MFHI/MFLO proceeds and reads the new HI/LO.
- Start is level-sampled only in IDLE. Start held high for several IDLE cycles launches back-to-back operations, one per 1+WIDTH cycles.
- HI/LO never change in RUN except on the final edge.

Test Plan:
- Reset held 3 cycles, then released -> HI=0, LO=0, Busy=0, Done=0, StallReq=0.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF, Start pulsed 1 cycle -> Busy high 32 cycles. Then HI=0xFFFFFFFE, LO=0x00000001, Done pulses 1 cycle.
- MULT A=-3, B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=100. DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
- Start DIVU 100/7, then HiLoAccess=1 on cycle 5 -> StallReq=1 until Done cycle. Independent instructions (HiLoAccess=0, Start=0) give StallReq=0 throughout. MFLO reads 14, MFHI reads 2.
- MULTU 5*5 started, Reset asserted at busy cycle 10 -> next cycle Busy=0, HI=LO=0, no Done. MTLO 0x1234 after that -> LO=0x1234 next edge.
